// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared state encoding and default timing for the ADC capture controller
package adc_capture_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CNV_HIGH  = 3'd1,
    CONV_WAIT = 3'd2,
    SCK_LOW   = 3'd3,
    SCK_HIGH  = 3'd4
  } state_t;
  localparam int DEF_DATA_WIDTH       = 16;
  localparam int DEF_CLK_DIV          = 4;
  localparam int DEF_CNV_HIGH_CYCLES  = 3;
  localparam int DEF_CONV_WAIT_CYCLES = 10;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/adc_phase_timer.sv
// adc_phase_timer: loadable down-counter with terminal-count flag for the timed FSM phases
module adc_phase_timer import adc_capture_pkg::*; #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // reload on every phase change, otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: CNV/SCK/SDO serial ADC initiator with one-cycle sample valid strobe
module adc_capture_ctrl import adc_capture_pkg::*; #(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int CLK_DIV          = DEF_CLK_DIV,
  parameter int CNV_HIGH_CYCLES  = DEF_CNV_HIGH_CYCLES,
  parameter int CONV_WAIT_CYCLES = DEF_CONV_WAIT_CYCLES
) (
  input  logic                  clk_p,
  input  logic                  reset_n_p,
  input  logic                  start_p,
  input  logic                  sdo_p,
  output logic                  cnv_p,
  output logic                  sck_p,
  output logic [DATA_WIDTH-1:0] data_p,
  output logic                  data_valid_p,
  output logic                  busy_p,
  output logic                  overrun_p
);
  localparam int CW = $clog2(max4(CLK_DIV, CNV_HIGH_CYCLES, CONV_WAIT_CYCLES, DATA_WIDTH + 1));
  state_t state, nxt;
  logic [CW-1:0] bit_cnt, load_val;
  logic [DATA_WIDTH-2:0] sh;
  logic load, tc, capture, last;
  adc_phase_timer #(.W(CW)) u_timer (
    .clk(clk_p),
    .rst_n(reset_n_p),
    .load(load),
    .load_val(load_val),
    .tc(tc)
  );
  assign capture   = state == SCK_LOW && tc;
  assign last      = bit_cnt == CW'(DATA_WIDTH - 1);
  assign cnv_p     = state == CNV_HIGH;
  assign sck_p     = state != SCK_LOW;
  assign busy_p    = state != IDLE;
  assign overrun_p = start_p && busy_p;
  // next state, and timer reload with the duration of the phase being entered
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = start_p ? CNV_HIGH : IDLE;
      CNV_HIGH:  nxt = tc ? CONV_WAIT : CNV_HIGH;
      CONV_WAIT: nxt = tc ? SCK_LOW : CONV_WAIT;
      SCK_LOW:   nxt = tc ? SCK_HIGH : SCK_LOW;
      SCK_HIGH:  nxt = !tc ? SCK_HIGH : bit_cnt < CW'(DATA_WIDTH) ? SCK_LOW : IDLE;
      default:   nxt = IDLE;
    endcase
    load     = nxt != state;
    load_val = nxt == CNV_HIGH ? CW'(CNV_HIGH_CYCLES - 1) :
               nxt == CONV_WAIT ? CW'(CONV_WAIT_CYCLES - 1) :
               (nxt == SCK_LOW || nxt == SCK_HIGH) ? CW'(CLK_DIV - 1) : '0;
  end
  // state register, MSB-first shift on the SCK rising edge, sample publish on the final bit
  always_ff @(posedge clk_p or negedge reset_n_p)
    if (!reset_n_p) begin
      state        <= IDLE;
      sh           <= '0;
      bit_cnt      <= '0;
      data_p       <= '0;
      data_valid_p <= 1'b0;
    end else begin
      state        <= nxt;
      data_valid_p <= capture && last;
      if (capture) begin
        sh      <= {sh[DATA_WIDTH-3:0], sdo_p};
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (capture && last) data_p <= {sh, sdo_p};
      if (state == SCK_HIGH && nxt == IDLE) bit_cnt <= '0;
    end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed checks of the ADC capture controller against a serial ADC model
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;
  logic clk_p = 1'b0;
  always #5 clk_p = ~clk_p;
  logic reset_n_p, start_p, sdo_p, cnv_p, sck_p, data_valid_p, busy_p, overrun_p;
  logic [15:0] data_p;
  logic start2, sdo2, cnv2, sck2, valid2, busy2, overrun2;
  logic [15:0] data2;
  int n_chk = 0;
  int n_fail = 0;
  adc_capture_ctrl dut (
    .clk_p(clk_p), .reset_n_p(reset_n_p), .start_p(start_p), .sdo_p(sdo_p),
    .cnv_p(cnv_p), .sck_p(sck_p), .data_p(data_p), .data_valid_p(data_valid_p),
    .busy_p(busy_p), .overrun_p(overrun_p)
  );
  adc_capture_ctrl #(.DATA_WIDTH(16), .CLK_DIV(2), .CNV_HIGH_CYCLES(1), .CONV_WAIT_CYCLES(1)) dut2 (
    .clk_p(clk_p), .reset_n_p(reset_n_p), .start_p(start2), .sdo_p(sdo2),
    .cnv_p(cnv2), .sck_p(sck2), .data_p(data2), .data_valid_p(valid2),
    .busy_p(busy2), .overrun_p(overrun2)
  );
  logic [15:0] mword = 16'h0, mword2 = 16'h0;
  int midx = 0, midx2 = 0;
  initial begin sdo_p = 1'b0; sdo2 = 1'b0; end
  always @(posedge cnv_p) midx = 0;
  always @(negedge sck_p) if (midx < 16) begin sdo_p = mword[15-midx]; midx++; end
  always @(posedge cnv2) midx2 = 0;
  always @(negedge sck2) if (midx2 < 16) begin sdo2 = mword2[15-midx2]; midx2++; end
  task automatic run_frame(input logic [15:0] w, input int extra, output int v_cyc, output int v_cnt,
                           output logic [15:0] v_data, output int end_cyc, output int ov_cyc, output int ov_cnt);
    mword = w; v_cyc = -1; v_cnt = 0; v_data = '0; end_cyc = -1; ov_cyc = -1; ov_cnt = 0;
    start_p = 1'b1;
    #1;
    if (overrun_p) begin ov_cnt++; ov_cyc = 0; end
    for (int t = 1; t <= 400 && end_cyc < 0; t++) begin
      @(posedge clk_p); #1;
      start_p = (t == extra);
      #1;
      if (overrun_p) begin ov_cnt++; ov_cyc = t; end
      if (data_valid_p) begin v_cnt++; v_cyc = t; v_data = data_p; end
      if (!busy_p) end_cyc = t;
    end
    start_p = 1'b0;
  endtask
  task automatic test_reset();
    reset_n_p = 1'b0; start_p = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk_p);
    #1;
    n_chk++; if (cnv_p !== 1'b0) begin n_fail++; $display("FAIL reset_cnv got %b want 0", cnv_p); end
    n_chk++; if (sck_p !== 1'b1) begin n_fail++; $display("FAIL reset_sck got %b want 1", sck_p); end
    n_chk++; if (data_p !== 16'h0) begin n_fail++; $display("FAIL reset_data got %h want 0000", data_p); end
    n_chk++; if (data_valid_p !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_valid_p); end
    n_chk++; if (busy_p !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_p); end
    n_chk++; if (overrun_p !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun_p); end
    n_chk++; if (sck2 !== 1'b1) begin n_fail++; $display("FAIL reset_sck2 got %b want 1", sck2); end
    reset_n_p = 1'b1;
    @(posedge clk_p); #1;
  endtask
  task automatic test_single();
    logic e_cnv, e_sck, e_busy, e_valid;
    mword = 16'hA5C3;
    start_p = 1'b1;
    for (int t = 1; t <= 145; t++) begin
      @(posedge clk_p); #1;
      start_p = 1'b0;
      #1;
      e_cnv = t >= 1 && t <= 3;
      e_sck = !(t >= 14 && t < 142 && ((t - 14) % 8) < 4);
      e_busy = t >= 1 && t <= 141;
      e_valid = t == 138;
      n_chk++; if (cnv_p !== e_cnv) begin n_fail++; $display("FAIL single_cnv c%0d got %b want %b", t, cnv_p, e_cnv); end
      n_chk++; if (sck_p !== e_sck) begin n_fail++; $display("FAIL single_sck c%0d got %b want %b", t, sck_p, e_sck); end
      n_chk++; if (busy_p !== e_busy) begin n_fail++; $display("FAIL single_busy c%0d got %b want %b", t, busy_p, e_busy); end
      n_chk++; if (data_valid_p !== e_valid) begin n_fail++; $display("FAIL single_valid c%0d got %b want %b", t, data_valid_p, e_valid); end
      n_chk++; if (overrun_p !== 1'b0) begin n_fail++; $display("FAIL single_overrun c%0d got %b want 0", t, overrun_p); end
      if (t == 138) begin
        n_chk++; if (data_p !== 16'hA5C3) begin n_fail++; $display("FAIL single_data got %h want a5c3", data_p); end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h0000, 16'hFFFF, 16'h8001};
    int v_cyc, v_cnt, end_cyc, ov_cyc, ov_cnt, base, prev;
    logic [15:0] v_data;
    base = 0; prev = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(words[i], -1, v_cyc, v_cnt, v_data, end_cyc, ov_cyc, ov_cnt);
      n_chk++; if (v_cnt !== 1) begin n_fail++; $display("FAIL b2b_valid_count f%0d got %0d want 1", i, v_cnt); end
      n_chk++; if (v_cyc !== 138) begin n_fail++; $display("FAIL b2b_valid_cycle f%0d got %0d want 138", i, v_cyc); end
      n_chk++; if (v_data !== words[i]) begin n_fail++; $display("FAIL b2b_data f%0d got %h want %h", i, v_data, words[i]); end
      n_chk++; if (end_cyc !== 142) begin n_fail++; $display("FAIL b2b_busy_fall f%0d got %0d want 142", i, end_cyc); end
      n_chk++; if (ov_cnt !== 0) begin n_fail++; $display("FAIL b2b_overrun f%0d got %0d want 0", i, ov_cnt); end
      if (i > 0) begin
        n_chk++; if (base + v_cyc - prev !== 142) begin n_fail++; $display("FAIL b2b_spacing f%0d got %0d want 142", i, base + v_cyc - prev); end
      end
      prev = base + v_cyc;
      base += end_cyc;
    end
  endtask
  task automatic test_overrun();
    int v_cyc, v_cnt, end_cyc, ov_cyc, ov_cnt;
    logic [15:0] v_data;
    run_frame(16'h6E19, 50, v_cyc, v_cnt, v_data, end_cyc, ov_cyc, ov_cnt);
    n_chk++; if (ov_cnt !== 1) begin n_fail++; $display("FAIL ovr_count got %0d want 1", ov_cnt); end
    n_chk++; if (ov_cyc !== 50) begin n_fail++; $display("FAIL ovr_cycle got %0d want 50", ov_cyc); end
    n_chk++; if (v_cnt !== 1) begin n_fail++; $display("FAIL ovr_valid_count got %0d want 1", v_cnt); end
    n_chk++; if (v_cyc !== 138) begin n_fail++; $display("FAIL ovr_valid_cycle got %0d want 138", v_cyc); end
    n_chk++; if (v_data !== 16'h6E19) begin n_fail++; $display("FAIL ovr_data got %h want 6e19", v_data); end
    n_chk++; if (end_cyc !== 142) begin n_fail++; $display("FAIL ovr_busy_fall got %0d want 142", end_cyc); end
  endtask
  task automatic test_reset_mid_frame();
    int v_cyc, v_cnt, end_cyc, ov_cyc, ov_cnt, nv;
    logic [15:0] v_data;
    mword = 16'hC0DE;
    start_p = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk_p); #1;
      start_p = 1'b0;
    end
    n_chk++; if (busy_p !== 1'b1) begin n_fail++; $display("FAIL rst_busy_before got %b want 1", busy_p); end
    reset_n_p = 1'b0;
    #1;
    n_chk++; if (sck_p !== 1'b1) begin n_fail++; $display("FAIL rst_sck got %b want 1", sck_p); end
    n_chk++; if (cnv_p !== 1'b0) begin n_fail++; $display("FAIL rst_cnv got %b want 0", cnv_p); end
    n_chk++; if (busy_p !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_p); end
    n_chk++; if (data_p !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0000", data_p); end
    nv = 0;
    repeat (2) begin @(posedge clk_p); #1; if (data_valid_p) nv++; end
    reset_n_p = 1'b1;
    repeat (200) begin @(posedge clk_p); #1; if (data_valid_p || busy_p) nv++; end
    n_chk++; if (nv !== 0) begin n_fail++; $display("FAIL rst_no_strobe got %0d want 0", nv); end
    run_frame(16'h3C5A, -1, v_cyc, v_cnt, v_data, end_cyc, ov_cyc, ov_cnt);
    n_chk++; if (v_cyc !== 138) begin n_fail++; $display("FAIL rst_next_cycle got %0d want 138", v_cyc); end
    n_chk++; if (v_data !== 16'h3C5A) begin n_fail++; $display("FAIL rst_next_data got %h want 3c5a", v_data); end
    n_chk++; if (v_cnt !== 1) begin n_fail++; $display("FAIL rst_next_count got %0d want 1", v_cnt); end
  endtask
  task automatic test_min_timing();
    int v_cyc, v_cnt, end_cyc;
    logic [15:0] v_data;
    v_cyc = -1; v_cnt = 0; end_cyc = -1; v_data = '0;
    mword2 = 16'h1234;
    start2 = 1'b1;
    for (int t = 1; t <= 100 && end_cyc < 0; t++) begin
      @(posedge clk_p); #1;
      start2 = 1'b0;
      if (valid2) begin v_cnt++; v_cyc = t; v_data = data2; end
      if (!busy2) end_cyc = t;
    end
    n_chk++; if (v_cyc !== 65) begin n_fail++; $display("FAIL min_valid_cycle got %0d want 65", v_cyc); end
    n_chk++; if (v_cnt !== 1) begin n_fail++; $display("FAIL min_valid_count got %0d want 1", v_cnt); end
    n_chk++; if (v_data !== 16'h1234) begin n_fail++; $display("FAIL min_data got %h want 1234", v_data); end
    n_chk++; if (end_cyc !== 67) begin n_fail++; $display("FAIL min_busy_fall got %0d want 67", end_cyc); end
  endtask
  task automatic test_idle();
    logic [15:0] hold;
    hold = 16'h3C5A;
    start_p = 1'b0;
    for (int t = 0; t < 1000; t++) begin
      @(posedge clk_p); #1;
      n_chk++; if (sck_p !== 1'b1) begin n_fail++; $display("FAIL idle_sck c%0d got %b want 1", t, sck_p); end
      n_chk++; if (cnv_p !== 1'b0) begin n_fail++; $display("FAIL idle_cnv c%0d got %b want 0", t, cnv_p); end
      n_chk++; if (data_valid_p !== 1'b0) begin n_fail++; $display("FAIL idle_valid c%0d got %b want 0", t, data_valid_p); end
      n_chk++; if (overrun_p !== 1'b0) begin n_fail++; $display("FAIL idle_overrun c%0d got %b want 0", t, overrun_p); end
      n_chk++; if (data_p !== hold) begin n_fail++; $display("FAIL idle_data c%0d got %h want %h", t, data_p, hold); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_min_timing();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
